// File: rtl/debug_cmd_rx.sv
// Line-oriented command parser for the UART debugger: turns "R <addr>\r" and
// "W <addr> <data>\r" byte streams into single valid/ready bus requests.
module debug_cmd_rx #(
    parameter int HEX_DIGITS = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    uart_recv,
    input  logic [7:0]              uart_din,
    output logic                    cmd_valid,
    input  logic                    cmd_ready,
    output logic                    cmd_write,
    output logic [4*HEX_DIGITS-1:0] cmd_addr,
    output logic [4*HEX_DIGITS-1:0] cmd_wdata,
    output logic                    parse_err,
    output logic                    busy
);

    localparam int FW = 4 * HEX_DIGITS;
    localparam int CW = $clog2(HEX_DIGITS + 1);

    localparam logic [7:0] CH_CR = 8'h0d;
    localparam logic [7:0] CH_LF = 8'h0a;
    localparam logic [7:0] CH_SP = 8'h20;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SP1,
        S_ADDR,
        S_DATA,
        S_PEND,
        S_DISCARD
    } state_t;

    state_t          state_q, state_d;
    logic            write_q, write_d;
    logic [FW-1:0]   addr_q, addr_d;
    logic [FW-1:0]   wdata_q, wdata_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            err_q, err_d;
    logic            valid_q, valid_d;
    logic            busy_q, busy_d;

    logic            is_hex;
    logic [3:0]      nibble;
    logic            field_full;
    logic            is_cr;
    logic            is_sp;

    // ASCII hex decode: letters map through their low nibble plus 9 (A/a = 1 -> 10).
    always_comb begin
        is_hex = 1'b0;
        nibble = 4'h0;
        if (uart_din >= 8'h30 && uart_din <= 8'h39) begin
            is_hex = 1'b1;
            nibble = uart_din[3:0];
        end else if ((uart_din >= 8'h41 && uart_din <= 8'h46) ||
                     (uart_din >= 8'h61 && uart_din <= 8'h66)) begin
            is_hex = 1'b1;
            nibble = uart_din[3:0] + 4'd9;
        end
    end

    assign field_full = (cnt_q == CW'(HEX_DIGITS));
    assign is_cr      = (uart_din == CH_CR);
    assign is_sp      = (uart_din == CH_SP);

    always_comb begin
        state_d = state_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;

        if (state_q == S_PEND) begin
            // The held command must stay intact, so any byte arriving now is lost.
            if (uart_recv) begin
                err_d = 1'b1;
            end
            if (valid_q && cmd_ready) begin
                state_d = S_IDLE;
            end
        end else if (uart_recv) begin
            case (state_q)
                S_IDLE: begin
                    if (uart_din == 8'h52 || uart_din == 8'h72) begin
                        state_d = S_SP1;
                        write_d = 1'b0;
                    end else if (uart_din == 8'h57 || uart_din == 8'h77) begin
                        state_d = S_SP1;
                        write_d = 1'b1;
                    end else if (!(is_cr || is_sp || uart_din == CH_LF)) begin
                        state_d = S_DISCARD;
                        err_d   = 1'b1;
                    end
                end
                S_SP1: begin
                    if (is_sp) begin
                        state_d = S_ADDR;
                        addr_d  = '0;
                        cnt_d   = '0;
                    end else if (is_cr) begin
                        state_d = S_IDLE;
                        err_d   = 1'b1;
                    end else begin
                        state_d = S_DISCARD;
                        err_d   = 1'b1;
                    end
                end
                S_ADDR: begin
                    if (is_hex) begin
                        if (field_full) begin
                            state_d = S_DISCARD;
                            err_d   = 1'b1;
                        end else begin
                            addr_d = {addr_q[FW-5:0], nibble};
                            cnt_d  = cnt_q + 1'b1;
                        end
                    end else if (is_sp && cnt_q != '0 && write_q) begin
                        state_d = S_DATA;
                        wdata_d = '0;
                        cnt_d   = '0;
                    end else if (is_cr && cnt_q != '0 && !write_q) begin
                        state_d = S_PEND;
                        wdata_d = '0;
                    end else if (is_cr) begin
                        state_d = S_IDLE;
                        err_d   = 1'b1;
                    end else begin
                        state_d = S_DISCARD;
                        err_d   = 1'b1;
                    end
                end
                S_DATA: begin
                    if (is_hex) begin
                        if (field_full) begin
                            state_d = S_DISCARD;
                            err_d   = 1'b1;
                        end else begin
                            wdata_d = {wdata_q[FW-5:0], nibble};
                            cnt_d   = cnt_q + 1'b1;
                        end
                    end else if (is_cr && cnt_q != '0) begin
                        state_d = S_PEND;
                    end else if (is_cr) begin
                        state_d = S_IDLE;
                        err_d   = 1'b1;
                    end else begin
                        state_d = S_DISCARD;
                        err_d   = 1'b1;
                    end
                end
                S_DISCARD: begin
                    if (is_cr) begin
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        valid_d = (state_d == S_PEND);
        busy_d  = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    assign cmd_valid = valid_q;
    assign cmd_write = write_q;
    assign cmd_addr  = addr_q;
    assign cmd_wdata = wdata_q;
    assign parse_err = err_q;
    assign busy      = busy_q;

endmodule

// File: doc/debug_cmd_rx.md
# debug_cmd_rx

Receive-side command decoder for the Lexington UART debugger. Consumes ASCII bytes delivered by the UART receiver (`uart_recv`/`uart_din`) and parses line-based read/write commands. The supported forms are `R <addr>\r` and `W <addr> <data>\r`, with hex-encoded address and data. Each well-formed command is presented as a single memory-access request on a valid/ready handshake toward the debug bus master; malformed lines are discarded and flagged.

## Interface
- `HEX_DIGITS`, 8: maximum hex digits per field; field width is 4*HEX_DIGITS bits (32).
- `clk`  input  1  system clock
- `rst`  input  1  reset, synchronous, active-high
- `uart_recv`  input  1  one-cycle pulse: `uart_din` holds a newly received byte
- `uart_din`  input  8  received byte
- `cmd_valid`  output  1  parsed command pending
- `cmd_ready`  input  1  consumer accepts the command
- `cmd_write`  output  1  1 = write, 0 = read
- `cmd_addr`  output  32  parsed address
- `cmd_wdata`  output  32  parsed write data; 0 for reads
- `parse_err`  output  1  one-cycle pulse on a syntax error or a dropped byte
- `busy`  output  1  high in any state other than IDLE

## Operation
- Hex digits: `0-9`, `a-f`, `A-F`. Per digit: `acc <= {acc[27:0], nibble}`. Fields are 1..HEX_DIGITS digits, zero-extended and right-aligned. There are no leading-zero rules.
- Only bytes in a cycle with `uart_recv`=1 are examined. All other cycles leave the parse state unchanged.

State machine (state updates on the byte's edge):
- **IDLE**
  - `R`/`r`: go to SP1 with `cmd_write`<=0.
  - `W`/`w`: go to SP1 with `cmd_write`<=1.
  - CR, LF, space: ignored.
  - Any other byte: go to DISCARD.
- **SP1**
  - Space: go to ADDR; clear address accumulator and digit count.
  - CR: go to IDLE and raise an error.
  - Any other byte: go to DISCARD.
- **ADDR**
  - Hex digit with count < HEX_DIGITS: shift into `cmd_addr`, count++.
  - Hex digit with count == HEX_DIGITS: go to DISCARD (overflow).
  - Space, count >= 1, write command: go to DATA; clear data accumulator and count.
  - CR, count >= 1, read command: go to PEND; `cmd_wdata`<=0.
  - CR on a write command, or CR with count 0: go to IDLE and raise an error.
  - Anything else: go to DISCARD.
- **DATA**
  - Same digit rules as ADDR, accumulating into `cmd_wdata`.
  - CR with count >= 1: go to PEND.
  - CR with count 0: go to IDLE and raise an error.
  - Anything else: go to DISCARD.
- **PEND**
  - `cmd_valid`=1.
  - On a `cmd_valid && cmd_ready` edge: go to IDLE.
  - Any byte received while in PEND, including on the handshake cycle, is dropped, raises an error, and does not change state.
- **DISCARD**
  - CR: go to IDLE silently.
  - All other bytes: ignored. LF alone does not exit.

Error rules:
- "Raise an error" means `parse_err`=1 for exactly the one cycle after the offending byte.
- Entering DISCARD raises an error once. Bytes ignored while in DISCARD raise none.

## Timing
- All outputs are registered.
- Reset values: `cmd_valid`=0, `cmd_write`=0, `cmd_addr`=0, `cmd_wdata`=0, `parse_err`=0, `busy`=0. State is IDLE, with accumulators and count cleared.
- Latency: a terminating CR sampled at edge N gives `cmd_valid`=1 from edge N onward, i.e. visible in cycle N+1.
- While `cmd_valid`=1, `cmd_write`/`cmd_addr`/`cmd_wdata` are held stable.
- Transfer occurs at an edge where `cmd_valid && cmd_ready`; `cmd_valid`=0 from the next cycle.
- `cmd_ready` may be high before `cmd_valid`; there is no combinational ready-to-valid path.
- Minimum command turnaround: a new line may begin on the first byte after the handshake edge.
- Reset mid-line or in PEND abandons the command. `cmd_valid` drops at the reset edge and no error pulse is generated.
- Accumulators are only updated on accepted digits. The address field remains visible on `cmd_addr` during DATA; consumers qualify with `cmd_valid` only.

## Test plan
- `"R 1000\r"` with `cmd_ready` held 1 -> one-cycle `cmd_valid` with `cmd_write`=0, `cmd_addr`=0x00001000, `cmd_wdata`=0; `parse_err` never asserts.
- `"w DEADbeef 12345678\r"` with `cmd_ready`=0 for 5 cycles, then 1 -> `cmd_valid` held 6 cycles with `cmd_write`=1, `cmd_addr`=0xDEADBEEF, `cmd_wdata`=0x12345678 stable throughout; `cmd_valid`=0 the cycle after ready.
- `"R 123456789\r"` (9 digits) -> `parse_err` pulses once on the 9th digit; no `cmd_valid`. A following `"R 4\r"` -> `cmd_addr`=0x4.
- `"W 10\r"`, then `"X\r"`, then `"R \r"` -> three single `parse_err` pulses; no `cmd_valid`; `busy`=0 after each CR.
- `"R 8\r"` with `cmd_ready`=0, then bytes `"R 9\r"` sent while pending -> 4 `parse_err` pulses; the pending command stays `cmd_addr`=0x8; after the handshake, `busy`=0.
- Reset asserted after `"W 20 3"` -> all outputs at reset values. A following `"R 5\r"` -> `cmd_addr`=0x5, `cmd_write`=0.
